// File: rtl/display_7seg_pkg.sv
// Shared definitions for the scanned 7-segment display receiver:
// bus field layout, glyph patterns (active-low a..g) and the capture FSM states.
package display_7seg_pkg;

    localparam int AN_W    = 4;
    localparam int SEG_W   = 7;
    localparam int BUS_W   = AN_W + SEG_W;
    localparam int AN_LSB  = 7;
    localparam int AN_MSB  = 10;
    localparam int SEG_LSB = 0;
    localparam int SEG_MSB = 6;

    localparam logic [SEG_W-1:0] GLYPH_0     = 7'h01;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'h12;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'h4C;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'h24;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'h20;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'h0F;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'h00;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'h04;
    localparam logic [SEG_W-1:0] GLYPH_A     = 7'h08;
    localparam logic [SEG_W-1:0] GLYPH_B     = 7'h60;
    localparam logic [SEG_W-1:0] GLYPH_C     = 7'h31;
    localparam logic [SEG_W-1:0] GLYPH_D     = 7'h42;
    localparam logic [SEG_W-1:0] GLYPH_E     = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_F     = 7'h38;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } scan_state_t;

    // Number of anodes driven low (active-low anode field).
    function automatic logic [2:0] anode_low_count(input logic [AN_W-1:0] an);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < AN_W; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

    // Digit index of a single low anode; only meaningful when exactly one is low.
    function automatic logic [1:0] anode_index(input logic [AN_W-1:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of an active-low a..g segment pattern into a hex nibble.
// legal: one of the 16 hex glyphs. blank: all segments off (not legal).
module seg7_glyph_decode
    import display_7seg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       nibble,
    output logic             legal,
    output logic             blank
);

    // Glyph lookup; anything not listed is illegal.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        blank  = 1'b0;
        case (pattern)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_7seg_rx.sv
// Receiver for a multiplexed 7-segment display bus: waits for each scanned
// digit to hold steady, decodes it, and reports per-digit validity, frame
// completion, error flags and a scan-stall indication.
module display_7seg_rx
    import display_7seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int STALL_CYCLES  = 2_000_000
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [BUS_W-1:0] display_in,
    output logic [15:0]      digits,
    output logic [3:0]       digit_ok,
    output logic             frame_valid,
    output logic             glyph_err,
    output logic             anode_err,
    output logic             scan_stalled
);

    localparam int SET_W   = $clog2(STABLE_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(STABLE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    logic [BUS_W-1:0]   sync1_r, sync2_r, prev_r, last_cap_r, last_cap_nxt_s;
    scan_state_t        state_r, state_nxt_s;
    logic [SET_W-1:0]   set_cnt_r, set_cnt_nxt_s, set_inc_s;
    logic [STALL_W-1:0] stall_cnt_r, stall_nxt_s;
    logic [15:0]        digits_r, digits_nxt_s;
    logic [3:0]         digit_ok_r, ok_nxt_s, seen_r, seen_nxt_s, sel_s;
    logic               frame_valid_r, fv_nxt_s, glyph_err_r, gerr_nxt_s;
    logic               anode_err_r, aerr_nxt_s, stalled_r, stalled_nxt_s;
    logic [2:0]         low_cnt_s;
    logic               one_low_s, multi_low_s, same_s, capture_s;
    logic [1:0]         cap_idx_s;
    logic [3:0]         dec_nibble_s;
    logic               dec_legal_s, dec_blank_s;

    assign low_cnt_s   = anode_low_count(sync2_r[AN_MSB:AN_LSB]);
    assign one_low_s   = (low_cnt_s == 3'd1);
    assign multi_low_s = (low_cnt_s > 3'd1);
    assign same_s      = (sync2_r == prev_r);
    assign set_inc_s   = set_cnt_r + SET_W'(1);
    assign capture_s   = (state_r == ST_CAPTURE) && !multi_low_s;
    // prev_r holds the settled pattern while in CAPTURE.
    assign cap_idx_s   = anode_index(prev_r[AN_MSB:AN_LSB]);
    assign sel_s       = 4'b0001 << cap_idx_s;

    seg7_glyph_decode u_decode (
        .pattern (prev_r[SEG_MSB:SEG_LSB]),
        .nibble  (dec_nibble_s),
        .legal   (dec_legal_s),
        .blank   (dec_blank_s)
    );

    // Two-flop synchroniser followed by a one-sample history for stability checks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 11'h7FF;
            sync2_r <= 11'h7FF;
            prev_r  <= 11'h7FF;
        end else begin
            sync1_r <= display_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // FSM state register and settle counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            set_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            set_cnt_r <= set_cnt_nxt_s;
        end
    end

    // Next-state logic: arm on a new single-anode pattern, settle, capture once.
    always_comb begin
        state_nxt_s   = state_r;
        set_cnt_nxt_s = set_cnt_r;
        case (state_r)
            ST_IDLE: begin
                set_cnt_nxt_s = '0;
                if (one_low_s && (sync2_r != last_cap_r)) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!one_low_s) begin
                    state_nxt_s   = ST_IDLE;
                    set_cnt_nxt_s = '0;
                end else if (!same_s) begin
                    set_cnt_nxt_s = '0;
                end else if (set_inc_s == SET_LAST) begin
                    set_cnt_nxt_s = set_inc_s;
                    state_nxt_s   = ST_CAPTURE;
                end else begin
                    set_cnt_nxt_s = set_inc_s;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s   = ST_IDLE;
                set_cnt_nxt_s = '0;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                set_cnt_nxt_s = '0;
            end
        endcase
        // A multi-anode sample aborts any capture in progress.
        if (multi_low_s) begin
            state_nxt_s   = ST_IDLE;
            set_cnt_nxt_s = '0;
        end else begin
            state_nxt_s   = state_nxt_s;
        end
    end

    // Capture datapath: digit data, validity, seen-mask, frame pulse and error flags.
    always_comb begin
        digits_nxt_s   = digits_r;
        ok_nxt_s       = digit_ok_r;
        seen_nxt_s     = seen_r;
        fv_nxt_s       = 1'b0;
        gerr_nxt_s     = glyph_err_r;
        aerr_nxt_s     = anode_err_r | multi_low_s;
        last_cap_nxt_s = last_cap_r;
        if (capture_s) begin
            last_cap_nxt_s = prev_r;
            if (dec_legal_s) begin
                digits_nxt_s[{cap_idx_s, 2'b00} +: 4] = dec_nibble_s;
            end else begin
                digits_nxt_s = digits_r;
            end
            ok_nxt_s[cap_idx_s] = dec_legal_s;
            gerr_nxt_s = glyph_err_r | ~(dec_legal_s | dec_blank_s);
            if ((seen_r | sel_s) == 4'hF) begin
                seen_nxt_s = 4'h0;
                fv_nxt_s   = 1'b1;
            end else begin
                seen_nxt_s = seen_r | sel_s;
            end
        end else begin
            last_cap_nxt_s = last_cap_r;
        end
    end

    // Stall counter: cleared by each capture, otherwise counts up to saturation.
    always_comb begin
        if (capture_s) begin
            stall_nxt_s = '0;
        end else if (stall_cnt_r != STALL_MAX) begin
            stall_nxt_s = stall_cnt_r + STALL_W'(1);
        end else begin
            stall_nxt_s = stall_cnt_r;
        end
        stalled_nxt_s = (stall_nxt_s == STALL_MAX);
    end

    // Output and capture-state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            digits_r      <= 16'h0000;
            digit_ok_r    <= 4'h0;
            seen_r        <= 4'h0;
            frame_valid_r <= 1'b0;
            glyph_err_r   <= 1'b0;
            anode_err_r   <= 1'b0;
            last_cap_r    <= 11'h7FF;
            stall_cnt_r   <= '0;
            stalled_r     <= 1'b0;
        end else begin
            digits_r      <= digits_nxt_s;
            digit_ok_r    <= ok_nxt_s;
            seen_r        <= seen_nxt_s;
            frame_valid_r <= fv_nxt_s;
            glyph_err_r   <= gerr_nxt_s;
            anode_err_r   <= aerr_nxt_s;
            last_cap_r    <= last_cap_nxt_s;
            stall_cnt_r   <= stall_nxt_s;
            stalled_r     <= stalled_nxt_s;
        end
    end

    assign digits       = digits_r;
    assign digit_ok     = digit_ok_r;
    assign frame_valid  = frame_valid_r;
    assign glyph_err    = glyph_err_r;
    assign anode_err    = anode_err_r;
    assign scan_stalled = stalled_r;

endmodule
